// File: rtl/l2_cfg_pkg.sv
// Shared definitions for the L2 layer parameter sequencer: FSM states,
// register map and error codes.
package l2_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_Q = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam logic [3:0] ADDR_W1_BASE  = 4'd0;
  localparam logic [3:0] ADDR_THR_BASE = 4'd8;
  localparam logic [3:0] ADDR_LAST     = 4'd11;

  localparam logic [1:0] ERR_ADDR = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  function automatic logic addr_is_weight(logic [3:0] a);
    return a < ADDR_THR_BASE;
  endfunction

  function automatic logic addr_is_thr(logic [3:0] a);
    return (a >= ADDR_THR_BASE) && (a <= ADDR_LAST);
  endfunction

endpackage

// File: rtl/l2_quiet_timer.sv
// Quiet-window and timeout counters for the commit wait phase.
// Both counters saturate; hit flags are qualified with the current cycle's inputs.
module l2_quiet_timer #(
  parameter int P_QUIET = 4,
  parameter int P_TMO   = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_run,
  input  logic i_quiet,
  output logic o_quiet_hit,
  output logic o_tmo_hit
);

  localparam int QW = $clog2(P_QUIET + 1);
  localparam int TW = $clog2(P_TMO + 1);
  localparam logic [QW-1:0] Q_LAST = QW'(P_QUIET - 1);
  localparam logic [TW-1:0] T_LAST = TW'(P_TMO - 1);

  logic [QW-1:0] qcnt;
  logic [TW-1:0] tcnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      qcnt <= '0;
      tcnt <= '0;
    end else if (i_clr) begin
      qcnt <= '0;
      tcnt <= '0;
    end else if (i_run) begin
      if (!i_quiet)        qcnt <= '0;
      else if (qcnt != '1) qcnt <= qcnt + 1'b1;
      if (tcnt != '1)      tcnt <= tcnt + 1'b1;
    end
  end

  assign o_quiet_hit = i_run && i_quiet && (qcnt == Q_LAST);
  assign o_tmo_hit   = i_run && (tcnt == T_LAST);

endmodule

// File: rtl/l2_param_sequencer.sv
// Shadow/active parameter banks for the 4-neuron L2 layer with a quiet-window
// atomic commit; events are deferred by one cycle across the commit edge.
module l2_param_sequencer
  import l2_cfg_pkg::*;
#(
  parameter int p_width = 9,
  parameter int P_QUIET = 4,
  parameter int P_TMO   = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_valid,
  output logic                       o_wr_ready,
  input  logic [3:0]                 i_wr_addr,
  input  logic [2*p_width:0]         i_wr_data,
  input  logic                       i_commit,
  input  logic [1:0]                 i_event,
  input  logic [3:0]                 i_spike_out,
  output logic [1:0]                 o_event,
  output logic [4*2*p_width-1:0]     o_weight,
  output logic [4*(2*p_width+1)-1:0] o_threshold,
  output logic                       o_busy,
  output logic                       o_commit_done,
  output logic                       o_err,
  output logic [1:0]                 o_err_code
);

  localparam int TW = 2*p_width + 1;

  state_e state;
  logic   forced;
  logic [1:0] hold;

  // Slice index equals register address, which matches the output bus packing.
  logic [7:0][p_width-1:0] sh_w, act_w;
  logic [3:0][TW-1:0]      sh_t, act_t;

  logic wr_fire, quiet, quiet_hit, tmo_hit;

  assign wr_fire = i_wr_valid && o_wr_ready;
  assign quiet   = (i_event == 2'b00) && (i_spike_out == 4'b0000);

  l2_quiet_timer #(.P_QUIET(P_QUIET), .P_TMO(P_TMO)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (state == ST_IDLE),
    .i_run      (state == ST_WAIT_Q),
    .i_quiet    (quiet),
    .o_quiet_hit(quiet_hit),
    .o_tmo_hit  (tmo_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      forced        <= 1'b0;
      hold          <= 2'b00;
      sh_w          <= '0;
      act_w         <= '0;
      sh_t          <= '1;
      act_t         <= '1;
      o_wr_ready    <= 1'b1;
      o_busy        <= 1'b0;
      o_commit_done <= 1'b0;
      o_err         <= 1'b0;
      o_err_code    <= 2'b00;
    end else begin
      o_commit_done <= 1'b0;
      o_err         <= 1'b0;
      // Events arriving during the commit cycle are replayed one cycle later.
      hold          <= (state == ST_COMMIT) ? i_event : 2'b00;

      if (wr_fire) begin
        if (addr_is_weight(i_wr_addr))
          sh_w[3'(i_wr_addr - ADDR_W1_BASE)] <= i_wr_data[p_width-1:0];
        else if (addr_is_thr(i_wr_addr))
          sh_t[2'(i_wr_addr - ADDR_THR_BASE)] <= i_wr_data;
        else begin
          o_err      <= 1'b1;
          o_err_code <= ERR_ADDR;
        end
      end

      unique case (state)
        ST_IDLE: if (i_commit) begin
          state      <= ST_WAIT_Q;
          forced     <= 1'b0;
          o_wr_ready <= 1'b0;
          o_busy     <= 1'b1;
        end
        ST_WAIT_Q: begin
          if (quiet_hit) state <= ST_COMMIT;
          else if (tmo_hit) begin
            state  <= ST_COMMIT;
            forced <= 1'b1;
          end
        end
        ST_COMMIT: begin
          act_w         <= sh_w;
          act_t         <= sh_t;
          o_commit_done <= 1'b1;
          if (forced) begin
            o_err      <= 1'b1;
            o_err_code <= ERR_TMO;
          end
          state      <= ST_IDLE;
          o_wr_ready <= 1'b1;
          o_busy     <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_event     = (state == ST_COMMIT) ? 2'b00 : (i_event | hold);
  assign o_weight    = act_w;
  assign o_threshold = act_t;

endmodule

// File: tb/tb_l2_param_sequencer.sv
// Randomized and directed bench for l2_param_sequencer against a cycle-level
// behavioural model of the commit protocol.
module tb_l2_param_sequencer;

  localparam int PW = 9;
  localparam int TW = 2*PW + 1;
  localparam int PQ = 4;
  localparam int PT = 255;

  localparam int M_IDLE   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_COMMIT = 2;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_wr_valid = 1'b0;
  logic            o_wr_ready;
  logic [3:0]      i_wr_addr = '0;
  logic [TW-1:0]   i_wr_data = '0;
  logic            i_commit = 1'b0;
  logic [1:0]      i_event = '0;
  logic [3:0]      i_spike_out = '0;
  logic [1:0]      o_event;
  logic [8*PW-1:0] o_weight;
  logic [4*TW-1:0] o_threshold;
  logic            o_busy, o_commit_done, o_err;
  logic [1:0]      o_err_code;

  l2_param_sequencer #(.p_width(PW), .P_QUIET(PQ), .P_TMO(PT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_commit(i_commit), .i_event(i_event),
    .i_spike_out(i_spike_out), .o_event(o_event), .o_weight(o_weight),
    .o_threshold(o_threshold), .o_busy(o_busy), .o_commit_done(o_commit_done),
    .o_err(o_err), .o_err_code(o_err_code)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural model
  int            m_phase, m_streak, m_elapsed;
  bit            m_forced, m_done, m_err;
  logic [1:0]    m_code, m_hold;
  logic [PW-1:0] sh_w[8], act_w[8];
  logic [TW-1:0] sh_t[4], act_t[4];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_streak = 0; m_elapsed = 0; m_forced = 0;
    m_done = 0; m_err = 0; m_code = 2'b00; m_hold = 2'b00;
    for (int a = 0; a < 8; a++) begin sh_w[a] = '0; act_w[a] = '0; end
    for (int t = 0; t < 4; t++) begin sh_t[t] = '1; act_t[t] = '1; end
  endtask

  task automatic model_step();
    bit q;
    int nxt;
    q = (i_event == 2'b00) && (i_spike_out == 4'b0000);
    m_done = 0; m_err = 0; m_hold = 2'b00;
    nxt = m_phase;
    if (m_phase == M_COMMIT) begin
      for (int a = 0; a < 8; a++) act_w[a] = sh_w[a];
      for (int t = 0; t < 4; t++) act_t[t] = sh_t[t];
      m_done = 1;
      if (m_forced) begin m_err = 1; m_code = 2'b10; end
      m_hold = i_event;
      nxt = M_IDLE;
    end
    if (m_phase == M_IDLE && i_wr_valid) begin
      if (i_wr_addr < 8)       sh_w[i_wr_addr[2:0]] = i_wr_data[PW-1:0];
      else if (i_wr_addr < 12) sh_t[i_wr_addr[1:0]] = i_wr_data;
      else begin m_err = 1; m_code = 2'b01; end
    end
    if (m_phase == M_IDLE && i_commit) begin
      nxt = M_WAIT; m_streak = 0; m_elapsed = 0; m_forced = 0;
    end else if (m_phase == M_WAIT) begin
      m_streak  = q ? m_streak + 1 : 0;
      m_elapsed = m_elapsed + 1;
      // Commit once P_QUIET quiet cycles in a row have been seen, else on timeout.
      if (m_streak == PQ) nxt = M_COMMIT;
      else if (m_elapsed == PT) begin nxt = M_COMMIT; m_forced = 1; end
    end
    m_phase = nxt;
  endtask

  function automatic logic [8*PW-1:0] exp_weight();
    logic [8*PW-1:0] r;
    for (int a = 0; a < 8; a++) r[a*PW +: PW] = act_w[a];
    return r;
  endfunction

  function automatic logic [4*TW-1:0] exp_thr();
    logic [4*TW-1:0] r;
    for (int t = 0; t < 4; t++) r[t*TW +: TW] = act_t[t];
    return r;
  endfunction

  task automatic compare_all();
    logic [1:0] ev;
    ev = (m_phase == M_COMMIT) ? 2'b00 : (i_event | m_hold);
    chk("wr_ready",    128'(o_wr_ready),    128'(m_phase == M_IDLE));
    chk("busy",        128'(o_busy),        128'(m_phase != M_IDLE));
    chk("commit_done", 128'(o_commit_done), 128'(m_done));
    chk("err",         128'(o_err),         128'(m_err));
    chk("err_code",    128'(o_err_code),    128'(m_code));
    chk("weight",      128'(o_weight),      128'(exp_weight()));
    chk("threshold",   128'(o_threshold),   128'(exp_thr()));
    chk("event",       128'(o_event),       128'(ev));
  endtask

  task automatic tick();
    @(negedge i_clk);
    compare_all();
    @(posedge i_clk);
    if (i_rst_n) model_step(); else model_reset();
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [TW-1:0] d);
    i_wr_valid = 1'b1; i_wr_addr = a; i_wr_data = d;
    tick();
    i_wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    while (!o_commit_done && n < maxc) begin tick(); n++; end
  endtask

  task automatic pulse_reset();
    i_rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy",  128'(o_busy),      128'(0));
    chk("rst_ready", 128'(o_wr_ready),  128'(1));
    chk("rst_wt",    128'(o_weight),    128'(0));
    chk("rst_thr",   128'(o_threshold), 128'({4*TW{1'b1}}));
    chk("rst_code",  128'(o_err_code),  128'(0));
    tick();
    i_rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [4*TW-1:0] thr_exp;
    model_reset();
    // Reset state
    @(negedge i_clk);
    compare_all();
    chk("reset_wt",    128'(o_weight),    128'(0));
    chk("reset_thr",   128'(o_threshold), 128'({4*TW{1'b1}}));
    chk("reset_ready", 128'(o_wr_ready),  128'(1));
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Quiet commit; the threshold write shares the cycle with i_commit
    wr(4'd1, 19'h00005);
    i_wr_valid = 1'b1; i_wr_addr = 4'd8; i_wr_data = 19'h00040; i_commit = 1'b1;
    tick();
    i_wr_valid = 1'b0; i_commit = 1'b0;
    chk("wait_busy", 128'(o_busy),   128'(1));
    chk("pre_wt",    128'(o_weight), 128'(0));
    wait_done(20, n);
    chk("lat_quiet", 128'(n),                  128'(5));
    chk("w2_n1",     128'(o_weight[17:9]),     128'(5));
    chk("thr_n1",    128'(o_threshold[18:0]),  128'(19'h40));
    chk("no_force",  128'(o_err),              128'(0));
    tick();

    // Events every other cycle until 20, then quiet
    i_commit = 1'b1; tick(); i_commit = 1'b0;
    n = 0;
    while (!o_commit_done && n < 60) begin
      n++;
      i_event = (n <= 20 && n % 2 == 0) ? 2'b01 : 2'b00;
      tick();
    end
    i_event = 2'b00;
    chk("lat_events", 128'(n),     128'(25));
    chk("ev_noforce", 128'(o_err), 128'(0));
    tick();

    // Continuous spikes force a timeout commit
    i_spike_out = 4'b0100;
    i_commit = 1'b1; tick(); i_commit = 1'b0;
    wait_done(300, n);
    chk("lat_tmo",  128'(n),          128'(256));
    chk("tmo_err",  128'(o_err),      128'(1));
    chk("tmo_code", 128'(o_err_code), 128'(2));
    i_spike_out = 4'b0000;
    tick();

    // Bad address dropped
    wr(4'd13, 19'h7ffff);
    chk("bad_err",  128'(o_err),      128'(1));
    chk("bad_code", 128'(o_err_code), 128'(1));
    i_commit = 1'b1; tick(); i_commit = 1'b0;
    wait_done(20, n);
    thr_exp = {{3{19'h7ffff}}, 19'h00040};
    chk("bad_wt",   128'(o_weight),    128'(72'hA00));
    chk("bad_thr",  128'(o_threshold), 128'(thr_exp));
    chk("code_hold",128'(o_err_code),  128'(1));
    tick();

    // Event landing in the commit cycle is deferred one cycle
    i_commit = 1'b1; tick(); i_commit = 1'b0;
    repeat (4) tick();
    i_event = 2'b10; #1;
    chk("ev_in_commit", 128'(o_event), 128'(0));
    tick();
    i_event = 2'b00; #1;
    chk("ev_replay",    128'(o_event),       128'(2'b10));
    chk("ev_done",      128'(o_commit_done), 128'(1));
    tick();

    // Reset during WAIT_Q discards shadow contents
    wr(4'd0, 19'h00033);
    i_commit = 1'b1; tick(); i_commit = 1'b0;
    tick(); tick();
    pulse_reset();
    i_commit = 1'b1; tick(); i_commit = 1'b0;
    wait_done(20, n);
    chk("post_rst_wt", 128'(o_weight), 128'(0));
    tick();

    // Randomized traffic with alternating busy/quiet stretches
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit noisy;
      noisy       = ((cyc / 150) % 2) == 1;
      i_wr_valid  = ($urandom % 4) == 0;
      i_wr_addr   = 4'($urandom_range(0, 15));
      i_wr_data   = TW'($urandom);
      i_commit    = ($urandom % 20) == 0;
      i_event     = (noisy ? ($urandom % 3) == 0 : ($urandom % 40) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      i_spike_out = (noisy ? ($urandom % 4) == 0 : ($urandom % 60) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      if ($urandom % 1500 == 0) pulse_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
